sp_series_proc: RTL and testbench

- Parametrised series processor. Per transaction it accepts a programmable chain of NUM_MODE operation codes followed by NUM_DATA data words, applies the operations in order, and streams NUM_DATA results out.
- Successor to the fixed 3-mode / 6-word series-processing block.
- Generalised in data width, vector length and chain depth.
- Adds multi-cycle sort stages and an abort-on-gap rule.

---
 rtl/sp_series_proc.sv | 278 +++++++++++++++++++++++++++
 tb/tb_sp_series_proc.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/sp_series_proc.sv
// sp_series_proc -- parametrised series processor.
//
// Per transaction the block takes NUM_MODE operation codes, then NUM_DATA
// data words, on consecutive in_valid cycles. It runs one processing stage
// per mode code, in order, over the data vector and streams the resulting
// NUM_DATA words out.
//
// Operation codes:
//   0 pass                       1 cycle
//   1 sort ascending             NUM_DATA cycles (odd-even transposition)
//   2 sort descending            NUM_DATA cycles
//   3 reverse order              1 cycle
//   4 prefix sum                 1 cycle
//   5 subtract vector minimum    1 cycle
//   6 rotate left by one         1 cycle
//   7 bitwise invert             1 cycle
//
// Configuration macro:
//   SP_SAT_EN  defined   -> prefix sum saturates at all-ones
//              undefined -> prefix sum wraps mod 2^DATA_W
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   high for NUM_MODE+NUM_DATA consecutive cycles per transaction;
//              a gap before the last word discards the transaction
//   in_mode    operation code, sampled on the first NUM_MODE valid cycles
//   in_data    data word, sampled on the last NUM_DATA valid cycles
//   out_valid  result word valid (NUM_DATA consecutive cycles)
//   out_data   result word, zero whenever out_valid is low
module sp_series_proc #(
  parameter int DATA_W   = 16,
  parameter int NUM_DATA = 6,
  parameter int NUM_MODE = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [2:0]        in_mode,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  localparam int MIW = (NUM_MODE > 1) ? $clog2(NUM_MODE) : 1;
  localparam int DIW = $clog2(NUM_DATA);
  localparam logic [MIW-1:0] LAST_MODE = MIW'(NUM_MODE - 1);
  localparam logic [DIW-1:0] LAST_DATA = DIW'(NUM_DATA - 1);

  typedef logic [NUM_DATA-1:0][DATA_W-1:0] vec_t;
  typedef logic [NUM_MODE-1:0][2:0]        modes_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_MODE,
    S_LOAD_DATA,
    S_PROC,
    S_OUT
  } state_t;

  // Prefix-sum adder: wraps, or clamps at all-ones when saturation is built in.
  // A clamped accumulator stays clamped because every addend is unsigned.
  function automatic logic [DATA_W-1:0] acc_add(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    logic [DATA_W:0] s;
    s = {1'b0, a} + {1'b0, b};
`ifdef SP_SAT_EN
    return s[DATA_W] ? {DATA_W{1'b1}} : s[DATA_W-1:0];
`else
    return s[DATA_W-1:0];
`endif
  endfunction

  // One odd-even transposition phase. Even phases compare pairs (0,1),(2,3)..;
  // odd phases compare (1,2),(3,4)... NUM_DATA phases fully sort the vector.
  // Pairs never overlap within a phase, so in-place swaps are safe.
  function automatic vec_t sort_phase(input vec_t v, input logic odd,
                                      input logic desc);
    vec_t r;
    logic [DATA_W-1:0] t;
    r = v;
    for (int i = 0; i < NUM_DATA - 1; i++) begin
      if (i[0] == odd) begin
        if (desc ? (r[i] < r[i+1]) : (r[i] > r[i+1])) begin
          t      = r[i];
          r[i]   = r[i+1];
          r[i+1] = t;
        end
      end
    end
    return r;
  endfunction

  function automatic vec_t prefix_sum(input vec_t v);
    vec_t r;
    logic [DATA_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < NUM_DATA; i++) begin
      acc  = acc_add(acc, v[i]);
      r[i] = acc;
    end
    return r;
  endfunction

  function automatic vec_t sub_min(input vec_t v);
    vec_t r;
    logic [DATA_W-1:0] mn;
    mn = v[0];
    for (int i = 1; i < NUM_DATA; i++) begin
      if (v[i] < mn) mn = v[i];
    end
    for (int i = 0; i < NUM_DATA; i++) begin
      r[i] = v[i] - mn;
    end
    return r;
  endfunction

  function automatic vec_t reverse_vec(input vec_t v);
    vec_t r;
    for (int i = 0; i < NUM_DATA; i++) begin
      r[i] = v[NUM_DATA-1-i];
    end
    return r;
  endfunction

  function automatic vec_t rotate_left(input vec_t v);
    vec_t r;
    for (int i = 0; i < NUM_DATA - 1; i++) begin
      r[i] = v[i+1];
    end
    r[NUM_DATA-1] = v[0];
    return r;
  endfunction

  // One clock of work for the current stage. Sort stages are applied once
  // per phase; every other operation completes in a single call.
  function automatic vec_t stage_step(input logic [2:0] m, input vec_t v,
                                      input logic odd_phase);
    vec_t r;
    case (m)
      3'd0:    r = v;
      3'd1:    r = sort_phase(v, odd_phase, 1'b0);
      3'd2:    r = sort_phase(v, odd_phase, 1'b1);
      3'd3:    r = reverse_vec(v);
      3'd4:    r = prefix_sum(v);
      3'd5:    r = sub_min(v);
      3'd6:    r = rotate_left(v);
      default: r = ~v;
    endcase
    return r;
  endfunction

  state_t            state_q, state_d;
  modes_t            modes_q, modes_d;
  vec_t              vec_q, vec_d;
  logic [MIW-1:0]    midx_q, midx_d;   // mode load index
  logic [MIW-1:0]    stg_q, stg_d;     // current processing stage
  logic [DIW-1:0]    didx_q, didx_d;   // data load / output index
  logic [DIW-1:0]    ph_q, ph_d;       // sort phase within a stage
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  logic [2:0]        cur_mode;
  logic              multi_cycle;

  always_comb begin
    state_d     = state_q;
    modes_d     = modes_q;
    vec_d       = vec_q;
    midx_d      = midx_q;
    stg_d       = stg_q;
    didx_d      = didx_q;
    ph_d        = ph_q;
    out_valid_d = 1'b0;
    out_data_d  = '0;
    cur_mode    = modes_q[stg_q];
    multi_cycle = (cur_mode == 3'd1) || (cur_mode == 3'd2);

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          modes_d[0] = in_mode;
          didx_d     = '0;
          if (NUM_MODE == 1) begin
            state_d = S_LOAD_DATA;
          end else begin
            midx_d  = MIW'(1);
            state_d = S_LOAD_MODE;
          end
        end
      end

      S_LOAD_MODE: begin
        if (!in_valid) begin
          state_d = S_IDLE;
        end else begin
          modes_d[midx_q] = in_mode;
          if (midx_q == LAST_MODE) begin
            didx_d  = '0;
            state_d = S_LOAD_DATA;
          end else begin
            midx_d = midx_q + 1'b1;
          end
        end
      end

      S_LOAD_DATA: begin
        if (!in_valid) begin
          state_d = S_IDLE;
        end else begin
          vec_d[didx_q] = in_data;
          if (didx_q == LAST_DATA) begin
            stg_d   = '0;
            ph_d    = '0;
            state_d = S_PROC;
          end else begin
            didx_d = didx_q + 1'b1;
          end
        end
      end

      S_PROC: begin
        vec_d = stage_step(cur_mode, vec_q, ph_q[0]);
        if (multi_cycle && (ph_q != LAST_DATA)) begin
          ph_d = ph_q + 1'b1;
        end else begin
          ph_d = '0;
          if (stg_q == LAST_MODE) begin
            didx_d  = '0;
            state_d = S_OUT;
          end else begin
            stg_d = stg_q + 1'b1;
          end
        end
      end

      S_OUT: begin
        out_valid_d = 1'b1;
        out_data_d  = vec_q[didx_q];
        if (didx_q == LAST_DATA) begin
          state_d = S_IDLE;
        end else begin
          didx_d = didx_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      modes_q     <= '0;
      vec_q       <= '0;
      midx_q      <= '0;
      stg_q       <= '0;
      didx_q      <= '0;
      ph_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      modes_q     <= modes_d;
      vec_q       <= vec_d;
      midx_q      <= midx_d;
      stg_q       <= stg_d;
      didx_q      <= didx_d;
      ph_q        <= ph_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_sp_series_proc.sv
module tb_sp_series_proc;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [2:0]  in_mode;
  logic [15:0] in_data;
  logic        out_valid;
  logic [15:0] out_data;

  int n_cmp;
  int n_fail;

  sp_series_proc #(.DATA_W(16), .NUM_DATA(6), .NUM_MODE(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_mode  (in_mode),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_data (out_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [0:2][2:0]  m;
    logic [0:5][15:0] d;
    logic [0:5][15:0] e;
    logic [7:0]       lat;
  } tvec_t;

  tvec_t tv [5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Drives modes then the first nd data words, one per clock; leaves the bench
  // at 1ns after the edge that sampled the last word, with in_valid low.
  task automatic send(input logic [0:2][2:0] m, input logic [0:5][15:0] d, input int nd);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_mode  = m[i];
      in_data  = 16'hxxxx;
      @(posedge clk); #1;
    end
    for (int i = 0; i < nd; i++) begin
      in_valid = 1'b1;
      in_mode  = 3'd0;
      in_data  = d[i];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  // Waits for out_valid, checks first-high edge count relative to E0, the six
  // words, and that the output returns to idle afterwards.
  task automatic expect_out(input string nm, input logic [0:5][15:0] e, input int lat);
    int k;
    bit found;
    k = 0;
    found = 1'b0;
    while (k < 60 && !found) begin
      @(posedge clk); #1;
      k++;
      if (out_valid) found = 1'b1;
    end
    if (!found) begin
      chk($sformatf("%s timeout out_valid", nm), 32'(out_valid), 32'd1);
    end else begin
      chk($sformatf("%s latency", nm), 32'(k), 32'(lat));
      for (int j = 0; j < 6; j++) begin
        if (j > 0) begin
          @(posedge clk); #1;
        end
        chk($sformatf("%s valid[%0d]", nm, j), 32'(out_valid), 32'd1);
        chk($sformatf("%s word[%0d]", nm, j), 32'(out_data), 32'(e[j]));
      end
      @(posedge clk); #1;
      chk($sformatf("%s valid_drop", nm), 32'(out_valid), 32'd0);
      chk($sformatf("%s data_zero", nm), 32'(out_data), 32'd0);
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_fail   = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_mode  = '0;
    in_data  = '0;

    tv[0] = '{m: {3'd1, 3'd4, 3'd0},
              d: {16'd5, 16'd3, 16'd9, 16'd1, 16'd7, 16'd2},
              e: {16'd1, 16'd3, 16'd6, 16'd11, 16'd18, 16'd27},
              lat: 8'd9};
    tv[1] = '{m: {3'd2, 3'd3, 3'd6},
              d: {16'd5, 16'd3, 16'd9, 16'd1, 16'd7, 16'd2},
              e: {16'd2, 16'd3, 16'd5, 16'd7, 16'd9, 16'd1},
              lat: 8'd9};
    tv[2] = '{m: {3'd5, 3'd0, 3'd7},
              d: {16'd5, 16'd3, 16'd9, 16'd1, 16'd7, 16'd2},
              e: {16'd65531, 16'd65533, 16'd65527, 16'd65535, 16'd65529, 16'd65534},
              lat: 8'd4};
`ifdef SP_SAT_EN
    tv[3] = '{m: {3'd4, 3'd0, 3'd0},
              d: {16'd40000, 16'd30000, 16'd1, 16'd2, 16'd3, 16'd4},
              e: {16'd40000, 16'd65535, 16'd65535, 16'd65535, 16'd65535, 16'd65535},
              lat: 8'd4};
`else
    tv[3] = '{m: {3'd4, 3'd0, 3'd0},
              d: {16'd40000, 16'd30000, 16'd1, 16'd2, 16'd3, 16'd4},
              e: {16'd40000, 16'd4464, 16'd4465, 16'd4467, 16'd4470, 16'd4474},
              lat: 8'd4};
`endif
    // Double rotate, then sort ascending last: sort must fully restore order.
    tv[4] = '{m: {3'd6, 3'd6, 3'd1},
              d: {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6},
              e: {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6},
              lat: 8'd9};

    // Reset state
    #12;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_data", 32'(out_data), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle out_valid", 32'(out_valid), 32'd0);

    for (int v = 0; v < 5; v++) begin
      send(tv[v].m, tv[v].d, 6);
      expect_out($sformatf("vec%0d", v), tv[v].e, int'(tv[v].lat));
    end

    // Gap abort: two data words then in_valid drops; no output may appear.
    begin
      int seen;
      seen = 0;
      send({3'd0, 3'd0, 3'd0}, {16'd10, 16'd20, 16'd0, 16'd0, 16'd0, 16'd0}, 2);
      for (int i = 0; i < 20; i++) begin
        @(posedge clk); #1;
        if (out_valid) seen++;
      end
      chk("gap no_output", 32'(seen), 32'd0);
    end
    send({3'd0, 3'd0, 3'd0}, {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6}, 6);
    expect_out("after_gap", {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6}, 4);

    // Asynchronous reset during OUT, after the second word.
    begin
      int k;
      k = 0;
      send({3'd0, 3'd0, 3'd0}, {16'd11, 16'd12, 16'd13, 16'd14, 16'd15, 16'd16}, 6);
      while (k < 60 && !out_valid) begin
        @(posedge clk); #1;
        k++;
      end
      chk("rstout first word", 32'(out_data), 32'd11);
      @(posedge clk); #1;
      chk("rstout second word", 32'(out_data), 32'd12);
      #2;
      rst = 1'b1;
      #1;
      chk("rstout async valid", 32'(out_valid), 32'd0);
      chk("rstout async data", 32'(out_data), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
        @(posedge clk); #1;
        if (out_valid) chk("rstout stays quiet", 32'(out_valid), 32'd0);
      end
    end
    send(tv[0].m, tv[0].d, 6);
    expect_out("after_rst", tv[0].e, int'(tv[0].lat));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
